// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-ported, fixed-latency synchronous memory
// between the instruction-fetch port and the data (load/store) port.
// A request is accepted only in IDLE. The data port has fixed priority.
// The winning request is latched and the memory strobe is issued for one cycle.
// After LATENCY cycles the read data is captured and the owner gets a one-cycle
// ready pulse.
module mem_arbiter #(
  parameter int unsigned LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  // instruction-fetch port
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ready,
  // data port
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_ready,
  // memory side
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  // status
  output logic        busy
);

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  // Legal LATENCY is 1..15, so the countdown fits in four bits.
  localparam logic [3:0] LAT = 4'(LATENCY);

  state_t      state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic        owner, owner_nxt;      // 1 = data port owns the access
  logic        store, store_nxt;      // in-flight access is a store

  logic        mem_en_nxt;
  logic        mem_we_nxt;
  logic [31:0] mem_addr_nxt;
  logic [31:0] mem_wdata_nxt;
  logic [31:0] if_rdata_nxt;
  logic [31:0] d_rdata_nxt;
  logic        if_ready_nxt;
  logic        d_ready_nxt;

  logic        if_elig;
  logic        d_elig;

  // A port whose ready pulse is high this cycle has just completed. Its req may
  // still be high from the finished transaction, so it must not be re-issued.
  assign if_elig = if_req & ~if_ready;
  assign d_elig  = d_req  & ~d_ready;

  assign busy = (state == WAIT);

  // Next-state, countdown and registered-output decode.
  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    owner_nxt     = owner;
    store_nxt     = store;
    mem_en_nxt    = 1'b0;
    mem_we_nxt    = 1'b0;
    mem_addr_nxt  = mem_addr;
    mem_wdata_nxt = mem_wdata;
    if_rdata_nxt  = if_rdata;
    d_rdata_nxt   = d_rdata;
    if_ready_nxt  = 1'b0;
    d_ready_nxt   = 1'b0;

    case (state)
      IDLE: begin
        if (d_elig || if_elig) begin
          // Data wins a tie: it belongs to the older instruction in the pipe.
          owner_nxt     = d_elig;
          store_nxt     = d_elig & d_we;
          mem_addr_nxt  = d_elig ? d_addr : if_addr;
          mem_wdata_nxt = d_wdata;
          mem_we_nxt    = d_elig & d_we;
          mem_en_nxt    = 1'b1;
          cnt_nxt       = LAT;
          state_nxt     = WAIT;
        end
      end

      WAIT: begin
        if (cnt != 4'd0) begin
          cnt_nxt = cnt - 4'd1;
        end else begin
          // mem_rdata is valid in this cycle; hand it to the owner.
          if (owner) begin
            d_ready_nxt = 1'b1;
            if (!store) begin
              d_rdata_nxt = mem_rdata;
            end
          end else begin
            if_ready_nxt = 1'b1;
            if_rdata_nxt = mem_rdata;
          end
          state_nxt = IDLE;
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Control state register: state, countdown, owner and access type.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= 4'd0;
      owner <= 1'b0;
      store <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      owner <= owner_nxt;
      store <= store_nxt;
    end
  end

  // Output registers; reset also discards any in-flight response.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= 32'd0;
      mem_wdata <= 32'd0;
      if_rdata  <= 32'd0;
      d_rdata   <= 32'd0;
      if_ready  <= 1'b0;
      d_ready   <= 1'b0;
    end else begin
      mem_en    <= mem_en_nxt;
      mem_we    <= mem_we_nxt;
      mem_addr  <= mem_addr_nxt;
      mem_wdata <= mem_wdata_nxt;
      if_rdata  <= if_rdata_nxt;
      d_rdata   <= d_rdata_nxt;
      if_ready  <= if_ready_nxt;
      d_ready   <= d_ready_nxt;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: directed scenarios on a LATENCY=2 and a LATENCY=1
// instance, then randomized two-port traffic against a transaction-level model.
module tb_mem_arbiter;

  localparam int L = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // LATENCY=2 instance
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ready;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_ready;
  logic        mem_en;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        busy;

  // LATENCY=1 instance
  logic        b_rst;
  logic        b_if_req;
  logic [31:0] b_if_addr;
  logic [31:0] b_if_rdata;
  logic        b_if_ready;
  logic        b_d_req;
  logic        b_d_we;
  logic [31:0] b_d_addr;
  logic [31:0] b_d_wdata;
  logic [31:0] b_d_rdata;
  logic        b_d_ready;
  logic        b_mem_en;
  logic        b_mem_we;
  logic [31:0] b_mem_addr;
  logic [31:0] b_mem_wdata;
  logic [31:0] b_mem_rdata;
  logic        b_busy;

  int n_vec = 0;
  int n_err = 0;

  mem_arbiter #(.LATENCY(L)) u_dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ready(d_ready),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  mem_arbiter #(.LATENCY(1)) u_dut1 (
    .clk(clk), .rst(b_rst),
    .if_req(b_if_req), .if_addr(b_if_addr), .if_rdata(b_if_rdata), .if_ready(b_if_ready),
    .d_req(b_d_req), .d_we(b_d_we), .d_addr(b_d_addr), .d_wdata(b_d_wdata),
    .d_rdata(b_d_rdata), .d_ready(b_d_ready),
    .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
    .mem_rdata(b_mem_rdata), .busy(b_busy)
  );

  // Contents of the behavioural memory: a fixed scramble of the address.
  function automatic logic [31:0] mhash(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A_5A5A;
  endfunction

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; b_rst = 1'b1;
    if_req = 1'b0; if_addr = 32'h0; d_req = 1'b0; d_we = 1'b0;
    d_addr = 32'h0; d_wdata = 32'h0; mem_rdata = 32'h0;
    b_if_req = 1'b0; b_if_addr = 32'h0; b_d_req = 1'b0; b_d_we = 1'b0;
    b_d_addr = 32'h0; b_d_wdata = 32'h0; b_mem_rdata = 32'h0;
    step; step;
    n_vec++;
    if ({if_ready, d_ready, mem_en, mem_we, busy} !== 5'b0 ||
        {if_rdata, d_rdata, mem_addr, mem_wdata} !== 128'b0) begin
      n_err++;
      $display("FAIL reset_l2: ctrl=%b ifr=%h dr=%h addr=%h wd=%h want all 0",
               {if_ready, d_ready, mem_en, mem_we, busy}, if_rdata, d_rdata, mem_addr, mem_wdata);
    end
    n_vec++;
    if ({b_if_ready, b_d_ready, b_mem_en, b_mem_we, b_busy} !== 5'b0 ||
        {b_if_rdata, b_d_rdata, b_mem_addr, b_mem_wdata} !== 128'b0) begin
      n_err++;
      $display("FAIL reset_l1: ctrl=%b ifr=%h dr=%h addr=%h wd=%h want all 0",
               {b_if_ready, b_d_ready, b_mem_en, b_mem_we, b_busy}, b_if_rdata, b_d_rdata,
               b_mem_addr, b_mem_wdata);
    end
    rst = 1'b0; b_rst = 1'b0;
    step;
    n_vec++;
    if ({mem_en, busy, if_ready, d_ready} !== 4'b0) begin
      n_err++;
      $display("FAIL reset_idle: got %b want 0000", {mem_en, busy, if_ready, d_ready});
    end
  endtask

  task automatic test_single_fetch;
    logic [4:0] got, exp;
    if_req = 1'b1; if_addr = 32'h10;
    for (int c = 1; c <= 6; c++) begin
      step;
      mem_rdata = (c == 3) ? 32'h0050_0093 : $urandom;
      got = {mem_en, mem_we, busy, if_ready, d_ready};
      exp = {c == 1, 1'b0, (c >= 1 && c <= 3), c == 4, 1'b0};
      n_vec++;
      if (got !== exp) begin
        n_err++;
        $display("FAIL single_fetch ctrl cyc %0d: got %b want %b", c, got, exp);
      end
      if (c == 1) begin
        n_vec++;
        if (mem_addr !== 32'h10) begin
          n_err++;
          $display("FAIL single_fetch addr: got %h want 00000010", mem_addr);
        end
      end
      if (c == 4) begin
        n_vec++;
        if (if_rdata !== 32'h0050_0093) begin
          n_err++;
          $display("FAIL single_fetch rdata: got %h want 00500093", if_rdata);
        end
        if_req = 1'b0;
      end
    end
  endtask

  task automatic test_simultaneous;
    logic [4:0] got, exp;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100;
    if_req = 1'b1; if_addr = 32'h14;
    for (int c = 1; c <= 10; c++) begin
      step;
      mem_rdata = (c == 3) ? 32'h1111_2222 : (c == 7) ? 32'h0000_0013 : $urandom;
      got = {mem_en, mem_we, busy, if_ready, d_ready};
      exp = {c == 1 || c == 5, 1'b0, (c >= 1 && c <= 3) || (c >= 5 && c <= 7), c == 8, c == 4};
      n_vec++;
      if (got !== exp) begin
        n_err++;
        $display("FAIL simultaneous ctrl cyc %0d: got %b want %b", c, got, exp);
      end
      if (c == 1 || c == 5) begin
        n_vec++;
        if (mem_addr !== ((c == 1) ? 32'h100 : 32'h14)) begin
          n_err++;
          $display("FAIL simultaneous addr cyc %0d: got %h want %h", c, mem_addr,
                   (c == 1) ? 32'h100 : 32'h14);
        end
      end
      if (c == 4) begin
        n_vec++;
        if (d_rdata !== 32'h1111_2222) begin
          n_err++;
          $display("FAIL simultaneous d_rdata: got %h want 11112222", d_rdata);
        end
        d_req = 1'b0;
      end
      if (c == 8) begin
        n_vec++;
        if (if_rdata !== 32'h0000_0013) begin
          n_err++;
          $display("FAIL simultaneous if_rdata: got %h want 00000013", if_rdata);
        end
        if_req = 1'b0;
      end
    end
  endtask

  task automatic test_store;
    logic [4:0] got, exp;
    // preload d_rdata with a known load result
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h300;
    for (int c = 1; c <= 5; c++) begin
      step;
      mem_rdata = (c == 3) ? 32'h1234_5678 : $urandom;
      if (c == 4) begin
        n_vec++;
        if (d_ready !== 1'b1 || d_rdata !== 32'h1234_5678) begin
          n_err++;
          $display("FAIL store_preload: ready=%b rdata=%h want 1 12345678", d_ready, d_rdata);
        end
        d_req = 1'b0;
      end
    end
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h200; d_wdata = 32'hDEAD_BEEF;
    for (int c = 1; c <= 6; c++) begin
      step;
      mem_rdata = $urandom;
      got = {mem_en, mem_we, busy, if_ready, d_ready};
      exp = {c == 1, c == 1, (c >= 1 && c <= 3), 1'b0, c == 4};
      n_vec++;
      if (got !== exp) begin
        n_err++;
        $display("FAIL store ctrl cyc %0d: got %b want %b", c, got, exp);
      end
      if (c == 1) begin
        n_vec++;
        if (mem_wdata !== 32'hDEAD_BEEF || mem_addr !== 32'h200) begin
          n_err++;
          $display("FAIL store latch: wdata=%h addr=%h want deadbeef 00000200", mem_wdata, mem_addr);
        end
        d_wdata = 32'h0; d_addr = 32'hFFFF_FFF0; d_we = 1'b0;
      end
      if (c == 4 || c == 6) begin
        n_vec++;
        if (d_rdata !== 32'h1234_5678) begin
          n_err++;
          $display("FAIL store d_rdata cyc %0d: got %h want 12345678", c, d_rdata);
        end
        d_req = 1'b0;
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [4:0] got, exp;
    if_req = 1'b1; if_addr = 32'h0;
    for (int c = 1; c <= 11; c++) begin
      step;
      mem_rdata = (c == 3) ? 32'h0000_00A0 : (c == 8) ? 32'h0000_00A4 : $urandom;
      got = {mem_en, mem_we, busy, if_ready, d_ready};
      exp = {c == 1 || c == 6, 1'b0, (c >= 1 && c <= 3) || (c >= 6 && c <= 8), c == 4 || c == 9, 1'b0};
      n_vec++;
      if (got !== exp) begin
        n_err++;
        $display("FAIL back_to_back ctrl cyc %0d: got %b want %b", c, got, exp);
      end
      if (c == 6) begin
        n_vec++;
        if (mem_addr !== 32'h4) begin
          n_err++;
          $display("FAIL back_to_back addr: got %h want 00000004", mem_addr);
        end
      end
      if (if_ready) begin
        n_vec++;
        if (if_rdata !== ((c == 4) ? 32'hA0 : 32'hA4)) begin
          n_err++;
          $display("FAIL back_to_back rdata cyc %0d: got %h want %h", c, if_rdata,
                   (c == 4) ? 32'hA0 : 32'hA4);
        end
        if (c == 4) if_addr = 32'h4;
        else if_req = 1'b0;
      end
    end
  endtask

  task automatic test_reset_midflight;
    logic [4:0] got, exp;
    if_req = 1'b1; if_addr = 32'h20;
    for (int c = 1; c <= 8; c++) begin
      step;
      mem_rdata = (c == 6) ? 32'h0000_0077 : 32'hBADB_AD00;
      got = {mem_en, mem_we, busy, if_ready, d_ready};
      exp = {c == 1 || c == 4, 1'b0, (c >= 1 && c <= 2) || (c >= 4 && c <= 6), c == 7, 1'b0};
      n_vec++;
      if (got !== exp) begin
        n_err++;
        $display("FAIL reset_midflight ctrl cyc %0d: got %b want %b", c, got, exp);
      end
      if (c == 2) rst = 1'b1;
      if (c == 3) begin
        n_vec++;
        if ({if_rdata, d_rdata, mem_addr, mem_wdata} !== 128'b0) begin
          n_err++;
          $display("FAIL reset_midflight regs: ifr=%h dr=%h addr=%h wd=%h want all 0",
                   if_rdata, d_rdata, mem_addr, mem_wdata);
        end
        rst = 1'b0;
      end
      if (c == 4) begin
        n_vec++;
        if (mem_addr !== 32'h20) begin
          n_err++;
          $display("FAIL reset_midflight addr: got %h want 00000020", mem_addr);
        end
      end
      if (c == 7) begin
        n_vec++;
        if (if_rdata !== 32'h77) begin
          n_err++;
          $display("FAIL reset_midflight rdata: got %h want 00000077", if_rdata);
        end
        if_req = 1'b0;
      end
    end
  endtask

  task automatic test_latency1;
    logic [4:0] got, exp;
    b_d_req = 1'b1; b_d_we = 1'b0; b_d_addr = 32'h40;
    for (int c = 1; c <= 5; c++) begin
      step;
      b_mem_rdata = (c == 2) ? 32'hCAFE_F00D : $urandom;
      got = {b_mem_en, b_mem_we, b_busy, b_if_ready, b_d_ready};
      exp = {c == 1, 1'b0, (c >= 1 && c <= 2), 1'b0, c == 3};
      n_vec++;
      if (got !== exp) begin
        n_err++;
        $display("FAIL latency1 ctrl cyc %0d: got %b want %b", c, got, exp);
      end
      if (c == 3) begin
        n_vec++;
        if (b_d_rdata !== 32'hCAFE_F00D) begin
          n_err++;
          $display("FAIL latency1 d_rdata: got %h want cafef00d", b_d_rdata);
        end
        b_d_req = 1'b0;
      end
    end
  endtask

  // Randomized traffic: each transaction, once accepted at cycle a, strobes the
  // memory at a+1, is busy through a+L+1 and completes at a+L+2.
  task automatic test_random(input int ncyc);
    bit          m_active, m_own_d, m_we;
    int          m_acc;
    logic [31:0] m_addr;
    logic [31:0] e_if_rdata, e_d_rdata, e_addr, e_wdata;
    bit          f_pend, f_acc, dp_pend, dp_acc;
    bit          s_vld;
    int          s_t;
    logic [31:0] s_data;
    bit          done, x_en, x_busy, x_ifr, x_dr;
    logic [4:0]  got, exp;

    m_active = 1'b0; m_own_d = 1'b0; m_we = 1'b0; m_acc = 0; m_addr = 32'h0;
    e_if_rdata = 32'h0; e_d_rdata = 32'h0; e_addr = 32'h0; e_wdata = 32'h0;
    f_pend = 1'b0; f_acc = 1'b0; dp_pend = 1'b0; dp_acc = 1'b0;
    s_vld = 1'b0; s_t = 0; s_data = 32'h0;
    if_req = 1'b0; d_req = 1'b0;
    rst = 1'b1;
    step;
    rst = 1'b0;

    for (int t = 0; t < ncyc; t++) begin
      if (t > 0) step;

      done   = m_active && (t == m_acc + L + 2);
      x_en   = m_active && (t == m_acc + 1);
      x_busy = m_active && (t > m_acc) && (t <= m_acc + L + 1);
      x_ifr  = done && !m_own_d;
      x_dr   = done && m_own_d;
      if (done) begin
        if (!m_own_d) e_if_rdata = mhash(m_addr);
        else if (!m_we) e_d_rdata = mhash(m_addr);
        m_active = 1'b0;
      end

      got = {mem_en, mem_we, busy, if_ready, d_ready};
      exp = {x_en, x_en && m_own_d && m_we, x_busy, x_ifr, x_dr};
      n_vec++;
      if (got !== exp) begin
        n_err++;
        $display("FAIL random ctrl t=%0d: got %b want %b", t, got, exp);
      end
      n_vec++;
      if ({if_rdata, d_rdata} !== {e_if_rdata, e_d_rdata}) begin
        n_err++;
        $display("FAIL random rdata t=%0d: got %h/%h want %h/%h", t, if_rdata, d_rdata,
                 e_if_rdata, e_d_rdata);
      end
      n_vec++;
      if ({mem_addr, mem_wdata} !== {e_addr, e_wdata}) begin
        n_err++;
        $display("FAIL random latch t=%0d: got %h/%h want %h/%h", t, mem_addr, mem_wdata,
                 e_addr, e_wdata);
      end

      // memory: data appears L cycles after the strobe, garbage otherwise
      if (s_vld && t == s_t) begin
        mem_rdata = s_data;
        s_vld = 1'b0;
      end else begin
        mem_rdata = $urandom;
      end
      if (mem_en === 1'b1) begin
        s_vld = 1'b1; s_t = t + L; s_data = mhash(mem_addr);
      end

      // fetch requester
      if (if_ready === 1'b1) begin f_pend = 1'b0; f_acc = 1'b0; end
      if (!f_pend) begin
        if ($urandom_range(0, 2) == 0) begin
          f_pend = 1'b1; if_req = 1'b1; if_addr = $urandom & 32'hFFFF_FFFC;
        end else begin
          if_req = 1'b0; if_addr = $urandom;
        end
      end else if (f_acc) begin
        if_req = ($urandom_range(0, 3) != 0); if_addr = $urandom;
      end

      // data requester
      if (d_ready === 1'b1) begin dp_pend = 1'b0; dp_acc = 1'b0; end
      if (!dp_pend) begin
        if ($urandom_range(0, 2) == 0) begin
          dp_pend = 1'b1; d_req = 1'b1; d_we = ($urandom_range(0, 1) == 1);
          d_addr = $urandom & 32'hFFFF_FFFC; d_wdata = $urandom;
        end else begin
          d_req = 1'b0; d_we = ($urandom_range(0, 1) == 1); d_addr = $urandom; d_wdata = $urandom;
        end
      end else if (dp_acc) begin
        d_req = ($urandom_range(0, 3) != 0); d_we = ($urandom_range(0, 1) == 1);
        d_addr = $urandom; d_wdata = $urandom;
      end

      // acceptance at the end of cycle t
      if (!m_active) begin
        if (d_req && !x_dr) begin
          m_active = 1'b1; m_acc = t; m_own_d = 1'b1; m_we = d_we; m_addr = d_addr;
          e_addr = d_addr; e_wdata = d_wdata; dp_acc = 1'b1;
        end else if (if_req && !x_ifr) begin
          m_active = 1'b1; m_acc = t; m_own_d = 1'b0; m_we = 1'b0; m_addr = if_addr;
          e_addr = if_addr; e_wdata = d_wdata; f_acc = 1'b1;
        end
      end
    end
    if_req = 1'b0; d_req = 1'b0;
  endtask

  initial begin
    rst = 1'b1; b_rst = 1'b1;
    test_reset;
    test_single_fetch;
    test_simultaneous;
    test_store;
    test_back_to_back;
    test_reset_midflight;
    test_latency1;
    test_random(3000);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
